cell_mem: RTL

- Synchronous cell-storage memory directly downstream of the cell allocator.
- The allocator hands out cell addresses; clients then read and write cell contents here.
- After reset, the block scrubs every word to INIT_VAL before accepting traffic, so freshly allocated cells always read a known value.
- Provides one-cycle read latency and sticky protocol-error reporting; the test wrapper samples this the same way it samples o_passed/o_error.

---
 rtl/cell_mem.sv | 106 ++++++++++
 1 files changed

// File: rtl/cell_mem.sv
// cell_mem: single-port cell storage sitting behind the cell allocator.
// After reset every word is scrubbed to INIT_VAL before o_ready rises.
// Reads return data one cycle later with a single o_valid pulse.
// Protocol errors are reported on o_error, which stays set until reset.
// Optional macro CELL_MEM_PARITY_EN adds one even-parity bit per word.
// The parity bit is checked on every read, and a mismatch also sets o_error.
module cell_mem #(
  parameter int                 DATA_SZ  = 16,
  parameter int                 ADDR_SZ  = 8,
  parameter logic [DATA_SZ-1:0] INIT_VAL = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  output logic               o_ready,
  input  logic               i_wr,
  input  logic               i_rd,
  input  logic [ADDR_SZ-1:0] i_addr,
  input  logic [DATA_SZ-1:0] i_data,
  output logic [DATA_SZ-1:0] o_data,
  output logic               o_valid,
  output logic               o_error
);

  localparam int DEPTH = 1 << ADDR_SZ;

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state, state_nxt;
  logic [ADDR_SZ-1:0]   ptr, ptr_nxt;
  logic [DATA_SZ-1:0]   mem [DEPTH];

  logic                 rd_ok, wr_ok, proto_err, par_err;
  logic                 mem_we;
  logic [ADDR_SZ-1:0]   mem_waddr;
  logic [DATA_SZ-1:0]   mem_wdata;

  logic                 vld_p1;
  logic [DATA_SZ-1:0]   data_p1;
  logic                 err_q;

  // Next-state logic: scrub walks the pointer; the wrap out of the last word ends CLEAR
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (i_en && state == CLEAR) begin
      ptr_nxt = ptr + ADDR_SZ'(1);
      if (&ptr) state_nxt = READY;
    end
  end

  // Request decode: the scrub owns the write port while CLEAR, clients own it afterwards
  always_comb begin
    rd_ok     = i_en && state == READY && i_rd && !i_wr;
    wr_ok     = i_en && state == READY && i_wr && !i_rd;
    proto_err = i_en && ((i_rd && i_wr) || (state == CLEAR && (i_rd || i_wr)));
    mem_we    = (i_en && state == CLEAR) || wr_ok;
    mem_waddr = (state == CLEAR) ? ptr : i_addr;
    mem_wdata = (state == CLEAR) ? INIT_VAL : i_data;
  end

  // Storage array: no reset, because the scrub defines the contents
  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

`ifdef CELL_MEM_PARITY_EN
  logic par_mem [DEPTH];

  function automatic logic even_par(input logic [DATA_SZ-1:0] d);
    return ^d;
  endfunction

  // Parity sidecar: written alongside every data word, scrub included
  always_ff @(posedge i_clk) begin
    if (mem_we) par_mem[mem_waddr] <= even_par(mem_wdata);
  end

  assign par_err = rd_ok && (par_mem[i_addr] != even_par(mem[i_addr]));
`else
  assign par_err = 1'b0;
`endif

  // Control and read-response registers; o_data only changes when a read completes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= CLEAR;
      ptr     <= '0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      vld_p1 <= rd_ok;
      if (rd_ok) data_p1 <= mem[i_addr];
      if (proto_err || par_err) err_q <= 1'b1;
    end
  end

  assign o_ready = (state == READY);
  assign o_valid = vld_p1;
  assign o_data  = data_p1;
  assign o_error = err_q;

endmodule
